// File: rtl/range_mon_pkg.sv
// Shared definitions for the range monitor: FSM state encoding and a constant clog2.
package range_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHK_HI = 2'd1,
    CHK_LO = 2'd2,
    UPD    = 2'd3
  } state_e;

  // Ceiling log2, usable in parameter/localparam expressions
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/range_monitor_sched_if.sv
// Sample handshake bus between the capture logic (master) and the range monitor (slave).
interface range_monitor_sched_if #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CH_W  = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [CH_W-1:0]  in_chan;
  logic [WIDTH-1:0] in_dat;

  modport master (output in_valid, output in_chan, output in_dat, input  in_ready);
  modport slave  (input  in_valid, input  in_chan, input  in_dat, output in_ready);
endinterface

// File: rtl/range_bound_cmp.sv
// Shared bound comparator: strict unsigned test against the upper or lower bound.
module range_bound_cmp #(
  parameter int unsigned           WIDTH       = 9,
  parameter logic [WIDTH-1:0]      UPPER_BOUND = 9'h0C9,
  parameter logic [WIDTH-1:0]      LOWER_BOUND = 9'h012
) (
  input  logic [WIDTH-1:0] dat,
  input  logic             over,
  output logic             out
);

  assign out = over ? (dat > UPPER_BOUND) : (dat < LOWER_BOUND);

endmodule

// File: rtl/range_monitor_sched.sv
// Multi-channel range alarm controller: one shared comparator, per-channel violation
// streaks, sticky alarms and a one-cycle irq when a streak reaches PERSIST.
module range_monitor_sched
  import range_mon_pkg::*;
#(
  parameter int unsigned      WIDTH       = 9,
  parameter int unsigned      CHANNELS    = 3,
  parameter int unsigned      CH_W        = 2,
  parameter logic [WIDTH-1:0] UPPER_BOUND = 9'h0C9,
  parameter logic [WIDTH-1:0] LOWER_BOUND = 9'h012,
  parameter int unsigned      PERSIST     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  range_monitor_sched_if.slave  s_if,
  input  logic                  clear,
  output logic [CHANNELS-1:0]   alarm,
  output logic [CHANNELS-1:0]   alarm_hi,
  output logic                  irq,
  output logic [CH_W-1:0]       irq_chan,
  output logic                  chan_err
);

  localparam int unsigned CNT_W = (clog2(PERSIST + 1) < 1) ? 1 : clog2(PERSIST + 1);
  localparam int unsigned CHW1  = CH_W + 1;

  if (PERSIST < 1) begin : g_chk_persist
    $error("range_monitor_sched: PERSIST must be >= 1");
  end
  if (CHANNELS < 1 || CHANNELS > (1 << CH_W)) begin : g_chk_chan
    $error("range_monitor_sched: CHANNELS must be in 1..2**CH_W");
  end

  state_e             r_state;
  logic               r_ready;
  logic [CH_W-1:0]    r_chan;
  logic [WIDTH-1:0]   r_dat;
  logic               r_viol;
  logic               r_side;
  logic               r_irq;
  logic [CH_W-1:0]    r_irq_chan;
  logic               r_chan_err;

  logic               w_hit;
  logic               w_over;
  logic               w_upd;
  logic [CHANNELS-1:0] w_fire;

  assign w_over = (r_state == CHK_HI);
  assign w_upd  = (r_state == UPD);

  range_bound_cmp #(
    .WIDTH       (WIDTH),
    .UPPER_BOUND (UPPER_BOUND),
    .LOWER_BOUND (LOWER_BOUND)
  ) u_cmp (
    .dat  (r_dat),
    .over (w_over),
    .out  (w_hit)
  );

  // Sequencer: accept, check high, check low, update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ready    <= 1'b1;
      r_chan     <= '0;
      r_dat      <= '0;
      r_viol     <= 1'b0;
      r_side     <= 1'b0;
      r_irq      <= 1'b0;
      r_irq_chan <= '0;
      r_chan_err <= 1'b0;
    end else begin
      r_irq      <= 1'b0;
      r_chan_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (s_if.in_valid) begin
            r_chan <= s_if.in_chan;
            r_dat  <= s_if.in_dat;
            if ({1'b0, s_if.in_chan} >= CHW1'(CHANNELS)) begin
              r_chan_err <= 1'b1;
            end else begin
              r_state <= CHK_HI;
              r_ready <= 1'b0;
            end
          end
        end
        CHK_HI: begin
          if (w_hit) begin
            r_viol  <= 1'b1;
            r_side  <= 1'b1;
            r_state <= UPD;
          end else begin
            r_state <= CHK_LO;
          end
        end
        CHK_LO: begin
          r_viol  <= w_hit;
          r_side  <= 1'b0;
          r_state <= UPD;
        end
        UPD: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          // A coincident clear discards the update, so it cannot raise irq either
          if (!clear && (|w_fire)) begin
            r_irq      <= 1'b1;
            r_irq_chan <= r_chan;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             r_alm;
    logic             r_alm_hi;
    logic             w_sel;

    assign w_sel     = w_upd && (r_chan == CH_W'(g));
    assign w_fire[g] = w_sel && r_viol && (r_cnt == CNT_W'(PERSIST - 1)) && !r_alm;

    // Saturating streak counter and sticky alarm for this channel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt    <= '0;
        r_alm    <= 1'b0;
        r_alm_hi <= 1'b0;
      end else if (clear) begin
        r_cnt    <= '0;
        r_alm    <= 1'b0;
        r_alm_hi <= 1'b0;
      end else if (w_sel) begin
        if (!r_viol) begin
          r_cnt <= '0;
        end else begin
          if (r_cnt != CNT_W'(PERSIST)) r_cnt <= r_cnt + CNT_W'(1);
          if (w_fire[g]) begin
            r_alm    <= 1'b1;
            r_alm_hi <= r_side;
          end
        end
      end
    end

    assign alarm[g]    = r_alm;
    assign alarm_hi[g] = r_alm_hi;
  end

  assign s_if.in_ready = r_ready;
  assign irq           = r_irq;
  assign irq_chan      = r_irq_chan;
  assign chan_err      = r_chan_err;

endmodule

// File: tb/tb_range_monitor_sched.sv
// Directed self-checking bench for range_monitor_sched (WIDTH=9, CHANNELS=3, PERSIST=3).
module tb_range_monitor_sched;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [2:0] alarm;
  logic [2:0] alarm_hi;
  logic       irq;
  logic [1:0] irq_chan;
  logic       chan_err;

  int n_checks = 0;
  int n_errors = 0;

  range_monitor_sched_if #(.WIDTH(9), .CH_W(2)) bus ();

  range_monitor_sched #(
    .WIDTH       (9),
    .CHANNELS    (3),
    .CH_W        (2),
    .UPPER_BOUND (9'd201),
    .LOWER_BOUND (9'd18),
    .PERSIST     (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_if     (bus),
    .clear    (clear),
    .alarm    (alarm),
    .alarm_hi (alarm_hi),
    .irq      (irq),
    .irq_chan (irq_chan),
    .chan_err (chan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] ch;
    logic [8:0] dat;
    bit         irq;
    logic [1:0] ichan;
    logic [2:0] alarm;
    logic [2:0] hi;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one sample from IDLE, wait for ready to return, then check the outcome
  task automatic do_sample(input logic [1:0] ch, input logic [8:0] dat, input bit clr_upd,
                           input int exp_busy, input bit exp_irq, input logic [1:0] exp_ichan,
                           input logic [2:0] exp_alarm, input logic [2:0] exp_hi,
                           input string name);
    int busy;
    busy = 0;
    chk({name, ".ready_in"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_chan  = ch;
    bus.in_dat   = dat;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.in_ready && busy < 10) begin
      busy++;
      if (clr_upd && busy == exp_busy) clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end
    chk({name, ".busy"},     32'(busy),     32'(exp_busy));
    chk({name, ".irq"},      32'(irq),      32'(exp_irq));
    if (exp_irq) chk({name, ".irq_chan"}, 32'(irq_chan), 32'(exp_ichan));
    chk({name, ".alarm"},    32'(alarm),    32'(exp_alarm));
    chk({name, ".alarm_hi"}, 32'(alarm_hi), 32'(exp_hi));
    chk({name, ".chan_err"}, 32'(chan_err), 32'd0);
  endtask

  initial begin
    int         gap;
    logic [8:0] gdat [4];
    int         gexp [4];

    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_chan  = '0;
    bus.in_dat   = '0;

    // ch2 persistent high violation; 4th sample must not re-irq
    vecs.push_back(vec_t'{2'd2, 9'd202, 1'b0, 2'd0, 3'b000, 3'b000});
    vecs.push_back(vec_t'{2'd2, 9'd202, 1'b0, 2'd0, 3'b000, 3'b000});
    vecs.push_back(vec_t'{2'd2, 9'd202, 1'b1, 2'd2, 3'b100, 3'b100});
    vecs.push_back(vec_t'{2'd2, 9'd202, 1'b0, 2'd0, 3'b100, 3'b100});
    // ch1 exactly at the bounds is in range
    for (int i = 0; i < 6; i++)
      vecs.push_back(vec_t'{2'd1, (i % 2 == 0) ? 9'd201 : 9'd18, 1'b0, 2'd0, 3'b100, 3'b100});
    vecs.push_back(vec_t'{2'd1, 9'd17, 1'b0, 2'd0, 3'b100, 3'b100});
    vecs.push_back(vec_t'{2'd1, 9'd17, 1'b0, 2'd0, 3'b100, 3'b100});
    vecs.push_back(vec_t'{2'd1, 9'd17, 1'b1, 2'd1, 3'b110, 3'b100});
    // ch0 broken streak, then reset-by-in-range, then mixed sides
    vecs.push_back(vec_t'{2'd0, 9'd250, 1'b0, 2'd0, 3'b110, 3'b100});
    vecs.push_back(vec_t'{2'd0, 9'd250, 1'b0, 2'd0, 3'b110, 3'b100});
    vecs.push_back(vec_t'{2'd0, 9'd100, 1'b0, 2'd0, 3'b110, 3'b100});
    vecs.push_back(vec_t'{2'd0, 9'd250, 1'b0, 2'd0, 3'b110, 3'b100});
    vecs.push_back(vec_t'{2'd0, 9'd250, 1'b0, 2'd0, 3'b110, 3'b100});
    vecs.push_back(vec_t'{2'd0, 9'd100, 1'b0, 2'd0, 3'b110, 3'b100});
    vecs.push_back(vec_t'{2'd0, 9'd250, 1'b0, 2'd0, 3'b110, 3'b100});
    vecs.push_back(vec_t'{2'd0, 9'd5,   1'b0, 2'd0, 3'b110, 3'b100});
    vecs.push_back(vec_t'{2'd0, 9'd250, 1'b1, 2'd0, 3'b111, 3'b101});

    repeat (2) @(negedge clk);
    #1;
    chk("rst.ready",    32'(bus.in_ready), 32'd1);
    chk("rst.alarm",    32'(alarm),        32'd0);
    chk("rst.irq",      32'(irq),          32'd0);
    chk("rst.chan_err", 32'(chan_err),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_sample(vecs[i].ch, vecs[i].dat, 1'b0, (vecs[i].dat > 9'd201) ? 2 : 3,
                vecs[i].irq, vecs[i].ichan, vecs[i].alarm, vecs[i].hi,
                $sformatf("vec%0d", i));
    end

    // Async reset while a sample sits in CHK_LO
    bus.in_valid = 1'b1;
    bus.in_chan  = 2'd0;
    bus.in_dat   = 9'd100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.ready",    32'(bus.in_ready), 32'd1);
    chk("midrst.alarm",    32'(alarm),        32'd0);
    chk("midrst.alarm_hi", 32'(alarm_hi),     32'd0);
    chk("midrst.irq",      32'(irq),          32'd0);
    chk("midrst.irq_chan", 32'(irq_chan),     32'd0);
    chk("midrst.chan_err", 32'(chan_err),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_sample(2'd0, 9'd250, 1'b0, 2, 1'b0, 2'd0, 3'b000, 3'b000, "post_rst");

    // clear coinciding with the 3rd violation's UPD discards it
    do_sample(2'd2, 9'd202, 1'b0, 2, 1'b0, 2'd0, 3'b000, 3'b000, "clr_a");
    do_sample(2'd2, 9'd202, 1'b0, 2, 1'b0, 2'd0, 3'b000, 3'b000, "clr_b");
    do_sample(2'd2, 9'd202, 1'b1, 2, 1'b0, 2'd0, 3'b000, 3'b000, "clr_upd");
    do_sample(2'd2, 9'd202, 1'b0, 2, 1'b0, 2'd0, 3'b000, 3'b000, "clr_d");
    do_sample(2'd2, 9'd202, 1'b0, 2, 1'b0, 2'd0, 3'b000, 3'b000, "clr_e");
    do_sample(2'd2, 9'd202, 1'b0, 2, 1'b1, 2'd2, 3'b100, 3'b100, "clr_f");

    // Out-of-range channel tag
    bus.in_valid = 1'b1;
    bus.in_chan  = 2'd3;
    bus.in_dat   = 9'd250;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("cerr.pulse", 32'(chan_err),     32'd1);
    chk("cerr.ready", 32'(bus.in_ready), 32'd1);
    chk("cerr.irq",   32'(irq),          32'd0);
    @(negedge clk);
    chk("cerr.end",   32'(chan_err),     32'd0);
    chk("cerr.alarm", 32'(alarm),        32'd4);

    // Back-to-back with in_valid held: ready gap per sample kind
    gdat[0] = 9'd250; gexp[0] = 2;
    gdat[1] = 9'd100; gexp[1] = 3;
    gdat[2] = 9'd5;   gexp[2] = 3;
    gdat[3] = 9'd201; gexp[3] = 3;
    bus.in_valid = 1'b1;
    bus.in_chan  = 2'd1;
    for (int i = 0; i < 4; i++) begin
      bus.in_dat = gdat[i];
      gap = 0;
      @(negedge clk);
      while (!bus.in_ready && gap < 10) begin
        gap++;
        @(negedge clk);
      end
      chk($sformatf("gap%0d", i), 32'(gap), 32'(gexp[i]));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
